// File: rtl/image_write_sched_pkg.sv
// image_write_sched_pkg
// Shared definitions for the image write scheduler and its blanking timer:
// the FSM state encoding, the 48-bit pixel-pair type, the default image
// geometry, and a helper that sizes the blanking down-counter.
package image_write_sched_pkg;

    localparam int DEF_WIDTH  = 768;
    localparam int DEF_HEIGHT = 512;
    localparam int DEF_HBLANK = 160;
    localparam int PIX_W      = 48;

    // Pixel pair {R0,G0,B0,R1,G1,B1}, 8 bits per component, R0 in the MSBs.
    typedef logic [PIX_W-1:0] pix_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_DONE
    } state_t;

    // The blanking counter only has to hold HBLANK-1, so clog2(HBLANK) bits
    // are enough; keep at least one bit so the counter never collapses.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/image_blank_timer.sv
// image_blank_timer
// Down-counter that times the idle gap between image rows.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   load     - load load_val into the counter (wins over count)
//   load_val - starting value, one less than the number of gap cycles
//   count    - decrement while non-zero
//   zero     - counter has reached zero (last gap cycle)
module image_blank_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority so a row end can restart the gap regardless of
    // where a previous gap left the counter; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/image_write_sched.sv
// image_write_sched
// Schedules pixel-pair writes for one image frame: accepts pairs from a
// source, forwards them to the image writer one cycle later with an hsync
// strobe, tracks row/column and inserts HBLANK idle cycles between rows.
// Optional feature macro: UNDERRUN_CHK_EN (sticky source-starvation flag).
// Ports:
//   HCLK, HRESETn  - clock (rising edge) and synchronous active-low reset
//   start, abort   - frame start (IDLE only) and frame termination
//   src_valid/pix  - source pixel pair and its valid flag
//   src_ready      - pair is accepted this cycle
//   hsync, wr_pix  - write strobe and pixel pair to the image writer
//   col, row       - next pair index in the row, current row index
//   busy           - any state other than IDLE
//   frame_done     - one-cycle pulse together with the final hsync
//   underrun       - sticky starvation flag (tied low without the macro)
module image_write_sched
    import image_write_sched_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int HBLANK = DEF_HBLANK
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         src_valid,
    input  logic [PIX_W-1:0]             src_pix,
    output logic                         src_ready,
    output logic                         hsync,
    output logic [PIX_W-1:0]             wr_pix,
    output logic [$clog2(WIDTH/2)-1:0]   col,
    output logic [$clog2(HEIGHT)-1:0]    row,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         underrun
);

    localparam int COL_W    = $clog2(WIDTH/2);
    localparam int ROW_W    = $clog2(HEIGHT);
    localparam int CNT_W    = cnt_width(HBLANK);
    localparam int LOAD_VAL = (HBLANK > 0) ? HBLANK - 1 : 0;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH/2 - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    state_t state;
    state_t state_next;

    logic xfer;
    logic col_at_end;
    logic last_row;
    logic row_end;
    logic start_ok;
    logic abort_ok;
    logic timer_load;
    logic timer_zero;

    assign src_ready  = (state == ST_ACTIVE) && !abort;
    assign xfer       = src_valid && src_ready;
    assign col_at_end = (col == COL_LAST);
    assign last_row   = (row == ROW_LAST);
    assign row_end    = xfer && col_at_end;
    assign start_ok   = (state == ST_IDLE) && start;
    assign abort_ok   = (state != ST_IDLE) && abort;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);
    assign timer_load = row_end && !last_row;

    // The gap timer is reloaded on every non-final row end and only counts
    // while the FSM sits in HBLANK; its zero flag marks the last gap cycle.
    image_blank_timer #(
        .CNT_W(CNT_W)
    ) u_blank_timer (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .load    (timer_load),
        .load_val(CNT_W'(LOAD_VAL)),
        .count   (state == ST_HBLANK),
        .zero    (timer_zero)
    );

    // State register.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A row end with HBLANK==0 stays in ACTIVE so rows
    // run back to back; abort from any busy state overrides everything.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (row_end) begin
                    if (last_row) begin
                        state_next = ST_DONE;
                    end else if (HBLANK == 0) begin
                        state_next = ST_ACTIVE;
                    end else begin
                        state_next = ST_HBLANK;
                    end
                end
            end
            ST_HBLANK: begin
                if (timer_zero) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort_ok) begin
            state_next = ST_IDLE;
        end
    end

    // Write path: an accepted pair appears on wr_pix with hsync exactly one
    // cycle later; without a transfer wr_pix simply holds. Abort does not
    // touch this path, so an hsync already owed is still delivered.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            hsync  <= 1'b0;
            wr_pix <= '0;
        end else begin
            hsync <= xfer;
            if (xfer) begin
                wr_pix <= src_pix;
            end
        end
    end

    // Position counters. The final row's index is left in place at frame end;
    // the next accepted start clears it along with the column.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            row <= '0;
            col <= '0;
        end else if (start_ok || abort_ok) begin
            row <= '0;
            col <= '0;
        end else if (xfer) begin
            if (col_at_end) begin
                col <= '0;
                if (!last_row) begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

`ifdef UNDERRUN_CHK_EN
    // Sticky starvation flag: any ACTIVE cycle without a valid source pair
    // sets it, and only reset or a newly accepted start clears it.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            underrun <= 1'b0;
        end else if (start_ok) begin
            underrun <= 1'b0;
        end else if ((state == ST_ACTIVE) && !src_valid) begin
            underrun <= 1'b1;
        end
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_image_write_sched.sv
// tb_image_write_sched
// Self-checking bench for image_write_sched. Two instances share the source,
// abort and reset inputs: dut_a uses WIDTH=8, HEIGHT=2, HBLANK=3 and dut_b
// the same geometry with HBLANK=0. Expected values come from a transfer
// schedule derived from the frame rules (earliest slot per pair, first valid
// cycle at or after it), not from the design's state machine.
module tb_image_write_sched;

    localparam int W     = 8;
    localparam int H     = 2;
    localparam int HB    = 3;
    localparam int PAIRS = W / 2;
    localparam int TOTAL = W * H / 2;
    localparam int MAXC  = 256;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start_a;
    logic        start_b;
    logic        abort;
    logic        src_valid;
    logic [47:0] src_pix;

    logic        ready_a, hsync_a, busy_a, done_a, und_a;
    logic [47:0] wr_pix_a;
    logic [1:0]  col_a;
    logic [0:0]  row_a;
    logic        ready_b, hsync_b, busy_b, done_b, und_b;
    logic [47:0] wr_pix_b;
    logic [1:0]  col_b;
    logic [0:0]  row_b;

    bit          sel;
    logic        obs_ready, obs_hsync, obs_busy, obs_done, obs_und;
    logic [47:0] obs_pix;
    logic [1:0]  obs_col;
    logic [0:0]  obs_row;

    int          check_count = 0;
    int          pass_count  = 0;
    int          fail_count  = 0;
    logic [47:0] last_pix [2];
    bit          sticky   [2];

    always #5 HCLK = ~HCLK;

    image_write_sched #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start_a), .abort(abort),
        .src_valid(src_valid), .src_pix(src_pix), .src_ready(ready_a),
        .hsync(hsync_a), .wr_pix(wr_pix_a), .col(col_a), .row(row_a),
        .busy(busy_a), .frame_done(done_a), .underrun(und_a)
    );

    image_write_sched #(.WIDTH(W), .HEIGHT(H), .HBLANK(0)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start_b), .abort(abort),
        .src_valid(src_valid), .src_pix(src_pix), .src_ready(ready_b),
        .hsync(hsync_b), .wr_pix(wr_pix_b), .col(col_b), .row(row_b),
        .busy(busy_b), .frame_done(done_b), .underrun(und_b)
    );

    assign obs_ready = sel ? ready_b  : ready_a;
    assign obs_hsync = sel ? hsync_b  : hsync_a;
    assign obs_pix   = sel ? wr_pix_b : wr_pix_a;
    assign obs_col   = sel ? col_b    : col_a;
    assign obs_row   = sel ? row_b    : row_a;
    assign obs_busy  = sel ? busy_b   : busy_a;
    assign obs_done  = sel ? done_b   : done_a;
    assign obs_und   = sel ? und_b    : und_a;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit ab, input bit rn,
                                 input bit v, input logic [47:0] p);
        start_a   = st && !sel;
        start_b   = st && sel;
        abort     = ab;
        HRESETn   = rn;
        src_valid = v;
        src_pix   = p;
    endtask

    // Runs one frame on the selected instance. mode 0: valid held high,
    // 1: valid toggling, 2: random. stop_at >= 0 ends the frame at that
    // cycle with abort (stop_is_reset=0) or a one-cycle reset (=1).
    // start is also pulsed in cycle 3, mid-frame, where it must be ignored.
    task automatic run_frame(input bit s, input int mode, input int stop_at,
                             input bit stop_is_reset);
        bit          vld [MAXC];
        logic [47:0] pix [MAXC];
        int          t     [TOTAL];
        int          early [TOTAL+1];
        int          ntx, e, cc, hb, stop, done_cyc, last_busy, end_c, m;
        bit          und_run, active, stopped_reset;
        bit          e_hs, e_busy, e_ready, e_done, e_und;
        logic [47:0] e_pix;
        string       tg;

        sel = s;
        hb  = s ? 0 : HB;
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0:       vld[c] = 1'b1;
                1:       vld[c] = (c % 2 == 1);
                default: vld[c] = (c % 4 == 0) ? 1'b1 : bit'($urandom_range(0, 1));
            endcase
            pix[c] = 48'({$urandom(), $urandom()});
        end
        stop = (stop_at >= 0) ? stop_at : MAXC;

        // Transfer schedule: pair k may go no earlier than one cycle after
        // pair k-1, plus the blanking gap when k starts a new row.
        ntx = 0;
        e   = 1;
        for (int k = 0; k < TOTAL; k++) begin
            early[k] = e;
            cc = e;
            while (cc < stop && cc < MAXC && !vld[cc]) cc++;
            if (cc >= stop || cc >= MAXC) break;
            t[k] = cc;
            ntx++;
            e = cc + 1 + (((k + 1) % PAIRS == 0) ? hb : 0);
        end
        early[ntx] = e;
        done_cyc   = (ntx == TOTAL && stop_at < 0) ? t[TOTAL-1] + 1 : -1;
        last_busy  = (stop_at >= 0) ? stop : done_cyc;
        end_c      = last_busy + 2;
        und_run    = 1'b0;

        for (int c = 0; c <= end_c; c++) begin
            applyStimulus(c == 0 || c == 3,
                          stop_at >= 0 && c == stop && !stop_is_reset,
                          !(stop_at >= 0 && c == stop && stop_is_reset),
                          vld[c], pix[c]);

            active = 1'b0;
            for (int k = 0; k < ntx; k++)
                if (c >= early[k] && c <= t[k]) active = 1'b1;
            if (ntx < TOTAL && c >= early[ntx] && c <= stop) active = 1'b1;

            e_hs  = 1'b0;
            e_pix = last_pix[s];
            m     = 0;
            for (int k = 0; k < ntx; k++) begin
                if (t[k] + 1 == c) e_hs = 1'b1;
                if (t[k] + 1 <= c) e_pix = pix[t[k]];
                if (t[k] < c) m++;
            end
            e_busy  = (c >= 1) && (c <= last_busy);
            e_ready = active && !(c == stop && !stop_is_reset);
            e_done  = (c == done_cyc);
`ifdef UNDERRUN_CHK_EN
            e_und = (c == 0) ? sticky[s] : und_run;
`else
            e_und = 1'b0;
`endif
            stopped_reset = stop_is_reset && stop_at >= 0 && c > stop;
            if (stopped_reset) begin
                e_hs  = 1'b0;
                e_pix = '0;
                e_und = 1'b0;
            end

            @(negedge HCLK);
            tg = $sformatf("sel%0d m%0d c%0d", s, mode, c);
            checkOutput({"hsync ", tg},      64'(obs_hsync), 64'(e_hs));
            checkOutput({"wr_pix ", tg},     64'(obs_pix),   64'(e_pix));
            checkOutput({"busy ", tg},       64'(obs_busy),  64'(e_busy));
            checkOutput({"src_ready ", tg},  64'(obs_ready), 64'(e_ready));
            checkOutput({"frame_done ", tg}, 64'(obs_done),  64'(e_done));
            checkOutput({"underrun ", tg},   64'(obs_und),   64'(e_und));
            if (c > 0 && (e_busy ? (c != done_cyc) : (stop_at >= 0))) begin
                checkOutput({"col ", tg}, 64'(obs_col), e_busy ? 64'(m % PAIRS) : 64'(0));
                checkOutput({"row ", tg}, 64'(obs_row), e_busy ? 64'(m / PAIRS) : 64'(0));
            end
            und_run = und_run | (active && !vld[c]);
            @(posedge HCLK);
            #1;
        end

        if (ntx > 0) last_pix[s] = pix[t[ntx-1]];
        sticky[s] = und_run;
        if (stop_is_reset && stop_at >= 0) begin
            last_pix[0] = '0;
            last_pix[1] = '0;
            sticky[0]   = 1'b0;
            sticky[1]   = 1'b0;
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        sel         = 1'b0;
        last_pix[0] = '0;
        last_pix[1] = '0;
        sticky[0]   = 1'b0;
        sticky[1]   = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge HCLK);

        // Reset state of both instances.
        @(negedge HCLK);
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            checkOutput($sformatf("reset hsync sel%0d", s),      64'(obs_hsync), 64'(0));
            checkOutput($sformatf("reset wr_pix sel%0d", s),     64'(obs_pix),   64'(0));
            checkOutput($sformatf("reset busy sel%0d", s),       64'(obs_busy),  64'(0));
            checkOutput($sformatf("reset frame_done sel%0d", s), 64'(obs_done),  64'(0));
            checkOutput($sformatf("reset underrun sel%0d", s),   64'(obs_und),   64'(0));
            checkOutput($sformatf("reset col sel%0d", s),        64'(obs_col),   64'(0));
            checkOutput($sformatf("reset row sel%0d", s),        64'(obs_row),   64'(0));
            checkOutput($sformatf("reset src_ready sel%0d", s),  64'(obs_ready), 64'(0));
        end
        sel = 1'b0;
        @(posedge HCLK);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        @(posedge HCLK);
        #1;

        $display("[TB] full frame, valid held high, HBLANK=3");
        run_frame(1'b0, 0, -1, 1'b0);
        $display("[TB] valid toggling every cycle");
        run_frame(1'b0, 1, -1, 1'b0);
        $display("[TB] full frame, HBLANK=0");
        run_frame(1'b1, 0, -1, 1'b0);
        $display("[TB] abort at row 1 col 2, then a full frame");
        run_frame(1'b0, 0, 10, 1'b0);
        run_frame(1'b0, 0, -1, 1'b0);
        $display("[TB] one-cycle reset during HBLANK, then a full frame");
        run_frame(1'b0, 0, 5, 1'b1);
        run_frame(1'b0, 0, -1, 1'b0);
        $display("[TB] random source valid on both instances");
        for (int i = 0; i < 3; i++) begin
            run_frame(1'b0, 2, -1, 1'b0);
            run_frame(1'b1, 2, -1, 1'b0);
        end
        run_frame(1'b1, 1, 12, 1'b0);
        run_frame(1'b1, 2, -1, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
